sequence_serializer: RTL and testbench

Parallel-to-serial front end for the Moore sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on `sequence_out`, which drives the detector's `sequence_in`. A one-word holding register lets consecutive words stream with no idle bits between them, so patterns that span word boundaries remain detectable.

---
 rtl/sequence_serializer.sv | 87 ++++++++
 tb/tb_sequence_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_serializer.sv
// sequence_serializer: MSB-first parallel-to-serial front end with a
// one-word holding register so consecutive words stream without gaps.
module sequence_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] pend_reg;
    logic             pend_full;

    logic accept;
    logic free;

    assign data_ready = !pend_full;
    assign busy       = bit_valid | pend_full;
    assign accept     = data_valid && data_ready;
    // Free also on the LSB cycle so the next word follows with no gap.
    assign free       = (state == IDLE) || (cnt == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shift_reg    <= '0;
            pend_reg     <= '0;
            pend_full    <= 1'b0;
            sequence_out <= IDLE_BIT;
            bit_valid    <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (free) begin
                if (pend_full) begin
                    sequence_out <= pend_reg[WIDTH-1];
                    shift_reg    <= {pend_reg[WIDTH-2:0], 1'b0};
                    cnt          <= '0;
                    bit_valid    <= 1'b1;
                    state        <= SHIFT;
                    pend_full    <= 1'b0;
                end else if (accept) begin
                    sequence_out <= data_in[WIDTH-1];
                    shift_reg    <= {data_in[WIDTH-2:0], 1'b0};
                    cnt          <= '0;
                    bit_valid    <= 1'b1;
                    state        <= SHIFT;
                end else begin
                    sequence_out <= IDLE_BIT;
                    bit_valid    <= 1'b0;
                    cnt          <= '0;
                    state        <= IDLE;
                end
            end else begin
                sequence_out <= shift_reg[WIDTH-1];
                shift_reg    <= {shift_reg[WIDTH-2:0], 1'b0};
                cnt          <= cnt + CW'(1);
                word_done    <= (cnt == PENULT);
                if (accept) begin
                    pend_reg  <= data_in;
                    pend_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sequence_serializer.sv
// tb_sequence_serializer: directed stimulus with a bit-level scoreboard
// and a cycle model of shifter occupancy and the pending slot.
module tb_sequence_serializer;

    typedef struct {
        logic b;
        logic last;
    } sb_bit_t;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       sequence_out;
    logic       bit_valid;
    logic       word_done;
    logic       busy;

    logic [3:0] d4;
    logic       v4;
    logic       ready4;
    logic       seq4;
    logic       bv4;
    logic       wd4;
    logic       busy4;

    int n_cmp = 0;
    int n_err = 0;

    sb_bit_t sb[$];
    int      m_left = 0;
    logic    m_pend = 1'b0;
    logic    m_acc = 1'b0;
    logic    chk_on = 1'b0;
    int      cyc = 0;

    logic    obs4[$];
    int      wd4_cnt = 0;
    int      first4 = -1;
    int      last4 = -1;

    sequence_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .sequence_out (sequence_out),
        .bit_valid    (bit_valid),
        .word_done    (word_done),
        .busy         (busy)
    );

    sequence_serializer #(.WIDTH(4), .IDLE_BIT(1'b0)) u_dut4 (
        .clock        (clock),
        .reset        (reset),
        .data_in      (d4),
        .data_valid   (v4),
        .data_ready   (ready4),
        .sequence_out (seq4),
        .bit_valid    (bv4),
        .word_done    (wd4),
        .busy         (busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Reference model: bits queued at accept, occupancy tracked per edge.
    always @(posedge clock) begin
        logic acc;
        cyc++;
        m_acc = 1'b0;
        if (!reset) begin
            m_left = 0;
            m_pend = 1'b0;
            sb.delete();
        end else begin
            acc = data_valid && !m_pend;
            if (acc) begin
                for (int i = 7; i >= 0; i--) begin
                    sb_bit_t e;
                    e.b = data_in[i];
                    e.last = (i == 0);
                    sb.push_back(e);
                end
            end
            m_acc = acc;
            if (m_left <= 1) begin
                if (m_pend) begin
                    m_left = 8;
                    m_pend = 1'b0;
                end else if (acc) begin
                    m_left = 8;
                end else begin
                    m_left = 0;
                end
            end else begin
                m_left--;
                if (acc) m_pend = 1'b1;
            end
        end
        chk_on = 1'b1;
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("data_ready", 32'(data_ready), 32'(!m_pend));
            chk("bit_valid", 32'(bit_valid), 32'(m_left != 0));
            chk("busy", 32'(busy), 32'((m_left != 0) || m_pend));
            if (m_left != 0) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    sb_bit_t e;
                    e = sb.pop_front();
                    chk("sequence_out", 32'(sequence_out), 32'(e.b));
                    chk("word_done", 32'(word_done), 32'(e.last));
                end
            end else begin
                chk("idle_out", 32'(sequence_out), 32'd0);
                chk("idle_word_done", 32'(word_done), 32'd0);
            end
            if (bv4 === 1'b1) begin
                obs4.push_back(seq4);
                if (first4 < 0) first4 = cyc;
                last4 = cyc;
            end
            if (wd4 === 1'b1) wd4_cnt++;
        end
    end

    initial begin
        logic [7:0] words [3];
        logic [7:0] got4;
        int i;
        int guard;

        words[0] = 8'hB4;
        words[1] = 8'h2D;
        words[2] = 8'hF0;
        d4 = 4'h0;
        v4 = 1'b0;

        // Reset held with a live handshake
        reset = 1'b0;
        data_valid = 1'b1;
        data_in = 8'hFF;
        repeat (3) tick();
        reset = 1'b1;
        data_valid = 1'b0;
        repeat (2) tick();

        // Single word
        data_in = 8'hB4;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (10) tick();

        // Back-to-back with valid held high
        i = 0;
        guard = 0;
        data_in = words[0];
        data_valid = 1'b1;
        while (i < 3 && guard < 100) begin
            tick();
            guard++;
            if (m_acc) begin
                i++;
                if (i < 3) data_in = words[i];
            end
        end
        data_valid = 1'b0;
        chk("b2b_accepts", 32'(i), 32'd3);
        repeat (30) tick();

        // Backpressure: data changes every cycle
        data_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            data_in = 8'($urandom);
            tick();
        end
        data_valid = 1'b0;
        repeat (30) tick();

        // Reset after the third bit with a word pending
        data_in = 8'hB4;
        data_valid = 1'b1;
        tick();
        data_in = 8'h2D;
        tick();
        data_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (12) tick();

        // WIDTH=4: two words streamed without a gap
        d4 = 4'hB;
        v4 = 1'b1;
        tick();
        d4 = 4'h5;
        tick();
        v4 = 1'b0;
        repeat (12) tick();

        got4 = 8'h00;
        foreach (obs4[k]) got4 = {got4[6:0], obs4[k]};
        chk("w4_bits", 32'(obs4.size()), 32'd8);
        chk("w4_stream", 32'(got4), 32'hB5);
        chk("w4_span", 32'(last4 - first4), 32'd7);
        chk("w4_done", 32'(wd4_cnt), 32'd2);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
